// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage feeding the 001001 detector: accepts a WIDTH-bit word
// over valid/ready and emits it one bit per cycle, MSB- or LSB-first, with no gap.
module seq_bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             msb_first,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Captured word context: shift data, bit order, bits remaining after the current one.
    typedef struct packed {
        logic [WIDTH-1:0] sh;
        logic             msb;
        logic [CW-1:0]    cnt;
    } word_t;

    state_t           state, state_n;
    word_t            word, word_n;
    logic             dout_n, dv_n, busy_n, wd_n;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign load_ready = (state == IDLE) || (state == SHIFT && word.cnt == '0);
    assign accept     = load_valid && load_ready;
    assign shifted    = word.msb ? (word.sh << 1) : (word.sh >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word       <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_n;
            word       <= word_n;
            dout       <= dout_n;
            dout_valid <= dv_n;
            busy       <= busy_n;
            word_done  <= wd_n;
        end
    end

    always_comb begin
        state_n = state;
        word_n  = word;
        dout_n  = dout;
        dv_n    = dout_valid;
        busy_n  = busy;
        wd_n    = 1'b0;
        case (state)
            IDLE: begin
                dout_n = IDLE_BIT;
                dv_n   = 1'b0;
                busy_n = 1'b0;
                if (accept) begin
                    word_n  = '{sh: load_data, msb: msb_first, cnt: LAST_CNT};
                    dout_n  = msb_first ? load_data[WIDTH-1] : load_data[0];
                    dv_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (word.cnt != '0) begin
                    word_n.sh  = shifted;
                    word_n.cnt = word.cnt - CW'(1);
                    dout_n     = word.msb ? shifted[WIDTH-1] : shifted[0];
                    wd_n       = (word.cnt == CW'(1));
                end else if (accept) begin
                    // Last bit on the line and a new word waiting: reload with no gap.
                    word_n = '{sh: load_data, msb: msb_first, cnt: LAST_CNT};
                    dout_n = msb_first ? load_data[WIDTH-1] : load_data[0];
                    dv_n   = 1'b1;
                    busy_n = 1'b1;
                end else begin
                    dout_n  = IDLE_BIT;
                    dv_n    = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the 001001 sequence detector and drives its din input. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clk cycle, either MSB-first or LSB-first. Back-to-back words stream with no idle gap. dout_valid marks the cycles that carry payload bits.

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
IDLE_BIT, 1'b0, value driven on dout when no word is being shifted.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous reset, active-high.
load_data  input  WIDTH  word to serialize; sampled on the accept edge.
load_valid  input  1  producer has a word on load_data.
load_ready  output  1  serializer can accept a word this cycle.
msb_first  input  1  bit order, sampled on the accept edge: 1 = MSB first, 0 = LSB first.
dout  output  1  serial bit stream; connects to the detector's din.
dout_valid  output  1  dout carries a payload bit this cycle.
busy  output  1  a word is being shifted.
word_done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- All outputs are registered except load_ready, which is combinational from the state and bit counter.
- Reset (rst=1 at a rising edge): state=IDLE, dout=IDLE_BIT, dout_valid=0, busy=0, word_done=0, bit counter=0, shift register=0.
  - Reset has priority over a load accepted on the same edge.
- Two states: IDLE and SHIFT.
  - Shift register is WIDTH bits.
  - Bit counter is clog2(WIDTH) bits and holds the number of bits remaining after the current one.
- load_ready = (state==IDLE) || (state==SHIFT && bit counter==0).
- Accept happens when load_valid && load_ready at a rising edge.
- IDLE, on accept:
  - Capture load_data and msb_first.
  - On the same edge, drive dout with the first bit (load_data[WIDTH-1] if MSB-first, load_data[0] if LSB-first).
  - dout_valid=1, busy=1, counter=WIDTH-1, go to SHIFT.
  - Latency: the first bit is visible in the cycle immediately after the accept edge.
- IDLE, no accept: hold dout=IDLE_BIT, dout_valid=0.
- SHIFT with counter>0, each edge:
  - Shift the register one position in the captured direction and present the next bit on dout.
  - Decrement the counter.
  - word_done=1 on the edge where the counter goes 1->0, so the pulse is coincident with the last bit; otherwise word_done=0.
- SHIFT with counter==0 (last bit on dout):
  - With accept: load the new word exactly as from IDLE and stay in SHIFT. There is no gap cycle, and dout_valid stays 1.
  - Without accept: go to IDLE, dout=IDLE_BIT, dout_valid=0, busy=0.
- load_valid while load_ready=0 is ignored. load_data is not sampled and no stall state is recorded.
- msb_first changes mid-word have no effect; the captured value governs the whole word.
- Each word produces exactly WIDTH cycles with dout_valid=1.
- Reset mid-word: the word is discarded and the next cycle shows the reset values.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with load_valid=1 -> dout=0, dout_valid=0, busy=0, word_done=0, no word accepted. After release, load_ready=1.
2. MSB-first: load 8'b0010_0100 with msb_first=1 -> dout = 0,0,1,0,0,1,0,0 over 8 consecutive dout_valid cycles. word_done=1 only in the 8th cycle, then IDLE with dout=0.
3. LSB-first: load 8'hA5 with msb_first=0 -> dout = 1,0,1,0,0,1,0,1. Toggling msb_first mid-word does not change this sequence.
4. Back-to-back: hold load_valid=1 with 8'h24 then 8'hFF -> 16 contiguous dout_valid cycles with no IDLE gap. load_ready is high only on the accept cycles. Two word_done pulses, 8 cycles apart.
5. Ignored load: pulse load_valid with 8'hFF while the 3rd bit of 8'h00 is shifting -> output stays all zeros for 8 bits. The 8'hFF is never emitted.
6. Reset mid-word: assert rst while the 4th bit of 8'hA5 is on dout -> next cycle dout=0, dout_valid=0, busy=0. A following load of 8'h24 serializes correctly from its first bit.
